// File: rtl/seg_disp_ctrl.sv
// Six-digit seven-segment display register block: round-robin arbitration of two
// writers onto the value/control registers, plus a blink timer gating the enable.
module seg_disp_ctrl #(
  parameter int BLINK_DIV = 12_500_000,
  parameter int CNT_W     = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       r0_valid,
  output logic       r0_ready,
  input  logic [1:0] r0_addr,
  input  logic [7:0] r0_data,
  input  logic       r1_valid,
  output logic       r1_ready,
  input  logic [1:0] r1_addr,
  input  logic [7:0] r1_data,
  output logic [7:0] segs_input0_1,
  output logic [7:0] segs_input2_3,
  output logic [7:0] segs_input4_5,
  output logic       segs_enable,
  output logic       blink_phase
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  logic             last_grant;
  logic             disp_on;
  logic             blink_en;
  logic [CNT_W-1:0] counter;

  logic             wr_en;
  logic [1:0]       wr_addr;
  logic [7:0]       wr_data;
  logic             ctrl_wr;
  logic             blink_en_next;
  logic             blink_rise;

  // Under contention the requester that did not win last time gets the grant.
  always_comb begin
    r0_ready = 1'b0;
    r1_ready = 1'b0;
    if (!rst) begin
      if (r0_valid && (!r1_valid || last_grant)) begin
        r0_ready = 1'b1;
      end else if (r1_valid) begin
        r1_ready = 1'b1;
      end
    end
  end

  always_comb begin
    wr_en   = r0_ready | r1_ready;
    wr_addr = r1_ready ? r1_addr : r0_addr;
    wr_data = r1_ready ? r1_data : r0_data;
  end

  always_comb begin
    ctrl_wr       = wr_en && (wr_addr == 2'd3);
    blink_en_next = ctrl_wr ? wr_data[1] : blink_en;
    blink_rise    = !blink_en && blink_en_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant    <= 1'b1;
      disp_on       <= 1'b1;
      blink_en      <= 1'b0;
      segs_input0_1 <= 8'h00;
      segs_input2_3 <= 8'h00;
      segs_input4_5 <= 8'h00;
    end else if (wr_en) begin
      last_grant <= r1_ready;
      case (wr_addr)
        2'd0: segs_input0_1 <= wr_data;
        2'd1: segs_input2_3 <= wr_data;
        2'd2: segs_input4_5 <= wr_data;
        default: begin
          disp_on  <= wr_data[0];
          blink_en <= wr_data[1];
        end
      endcase
    end
  end

  // The control write decides blink_en first; a wrap only counts if blink stays on.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter     <= '0;
      blink_phase <= 1'b1;
    end else if (blink_rise || !blink_en_next) begin
      counter     <= '0;
      blink_phase <= 1'b1;
    end else if (counter == CNT_MAX) begin
      counter     <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      counter     <= counter + 1'b1;
    end
  end

  assign segs_enable = disp_on & (~blink_en | blink_phase);

endmodule
